pipeline_controller: RTL and testbench

//  Sequences the 5-stage RISC-V pipeline from ID: scoreboards in-flight destination regs, stalls on RAW hazards,

---
 rtl/pipeline_pkg.sv | 43 ++++
 rtl/pipeline_controller_if.sv | 26 ++
 rtl/pipeline_controller_rd_scoreboard.sv | 38 +++
 rtl/pipeline_controller.sv | 125 ++++++++++++
 tb/tb_pipeline_controller.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the ID-stage pipeline controller: opcode values, FSM states, NOP encoding
// and the opcode decode helper.
package pipeline_pkg;

    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_BR_WAIT = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic reads_rs1;
        logic reads_rs2;
        logic writes_rd;
        logic is_ctrl;
    } decode_t;

    function automatic decode_t decode_op(input logic [6:0] op);
        decode_t d;
        case (op)
            OP_RTYPE:          d = '{1'b1, 1'b1, 1'b1, 1'b0};
            OP_STORE:          d = '{1'b1, 1'b1, 1'b0, 1'b0};
            OP_BRANCH:         d = '{1'b1, 1'b1, 1'b0, 1'b1};
            OP_LOAD, OP_OPIMM: d = '{1'b1, 1'b0, 1'b1, 1'b0};
            OP_JALR:           d = '{1'b1, 1'b0, 1'b1, 1'b1};
            OP_JAL:            d = '{1'b0, 1'b0, 1'b1, 1'b1};
            OP_LUI, OP_AUIPC:  d = '{1'b0, 1'b0, 1'b1, 1'b0};
            default:           d = '{1'b0, 1'b0, 1'b0, 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// ID-stage handshake bundle between the instruction source / pipeline datapath and the controller.
interface pipeline_controller_if #(parameter int CNT_W = 16);

    logic             id_valid;
    logic [6:0]       opcode;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             branch_taken;
    logic             pc_load;
    logic             if_id_load;
    logic             if_id_flush;
    logic             mux5_selector;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, opcode, rs1, rs2, rd, branch_taken,
        input  pc_load, if_id_load, if_id_flush, mux5_selector, stall_cycles
    );

    modport slave (
        input  id_valid, opcode, rs1, rs2, rd, branch_taken,
        output pc_load, if_id_load, if_id_flush, mux5_selector, stall_cycles
    );

endinterface

// File: rtl/pipeline_controller_rd_scoreboard.sv
// Shift register of in-flight destination registers (EX, MEM, WB); reports whether ID sources
// collide with any of them. An entry of 0 means "nothing tracked".
module rd_scoreboard #(
    parameter int DEPTH = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_en,
    input  logic [4:0] push_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       rs1_match,
    output logic       rs2_match
);

    logic [4:0] sb_r [DEPTH];

    // advance one stage per cycle; non-issuing cycles inject an empty slot
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) sb_r[i] <= 5'd0;
        end else begin
            sb_r[0] <= push_en ? push_rd : 5'd0;
            for (int i = 1; i < DEPTH; i++) sb_r[i] <= sb_r[i-1];
        end
    end

    // x0 is never a dependency, so a zero source can never match
    always_comb begin
        rs1_match = 1'b0;
        rs2_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rs1_match = rs1_match | ((rs1 != 5'd0) && (sb_r[i] == rs1));
            rs2_match = rs2_match | ((rs2 != 5'd0) && (sb_r[i] == rs2));
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// ID-stage pipeline sequencer: RAW-hazard stalls, branch hold/resolve/flush, bubble injection
// and a saturating stall-cycle counter.
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int BRANCH_LAT = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    pipeline_controller_if.slave  bus
);

    localparam int              BCNT_W    = $clog2(BRANCH_LAT + 1);
    localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(BRANCH_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    ctrl_state_e       state_r, state_next_s;
    logic [BCNT_W-1:0] bcnt_r, bcnt_next_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    decode_t           dec_s;
    logic              rs1_match_s, rs2_match_s;
    logic              data_hazard_s, issue_s, push_en_s;
    logic              pc_load_s, if_id_load_s, if_id_flush_s, mux5_s;

    assign dec_s         = decode_op(bus.opcode);
    assign data_hazard_s = bus.id_valid && ((dec_s.reads_rs1 && rs1_match_s) ||
                                            (dec_s.reads_rs2 && rs2_match_s));
    assign issue_s       = bus.id_valid && !data_hazard_s && (state_r == ST_IDLE);
    assign push_en_s     = issue_s && dec_s.writes_rd;

    rd_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clock     (clock),
        .reset     (reset),
        .push_en   (push_en_s),
        .push_rd   (bus.rd),
        .rs1       (bus.rs1),
        .rs2       (bus.rs2),
        .rs1_match (rs1_match_s),
        .rs2_match (rs2_match_s)
    );

    // state and branch countdown registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            bcnt_r  <= '0;
        end else begin
            state_r <= state_next_s;
            bcnt_r  <= bcnt_next_s;
        end
    end

    // next-state: a control-flow instruction opens a BRANCH_LAT-cycle wait window
    always_comb begin
        state_next_s = state_r;
        bcnt_next_s  = bcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s && dec_s.is_ctrl) begin
                    state_next_s = ST_BR_WAIT;
                    bcnt_next_s  = BCNT_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BR_WAIT: begin
                if (bcnt_r != '0) begin
                    bcnt_next_s = bcnt_r - BCNT_W'(1);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                bcnt_next_s  = '0;
            end
        endcase
    end

    // pipeline control outputs, highest priority first
    always_comb begin
        pc_load_s     = 1'b1;
        if_id_load_s  = 1'b1;
        if_id_flush_s = 1'b0;
        mux5_s        = 1'b1;
        if (reset || ((state_r == ST_BR_WAIT) && (bcnt_r != '0))) begin
            pc_load_s    = 1'b0;
            if_id_load_s = 1'b0;
        end else if (state_r == ST_BR_WAIT) begin
            if_id_flush_s = bus.branch_taken;
        end else if (data_hazard_s) begin
            pc_load_s    = 1'b0;
            if_id_load_s = 1'b0;
        end else if (issue_s && dec_s.is_ctrl) begin
            // branch moves into EX while fetch is frozen until it resolves
            pc_load_s    = 1'b0;
            if_id_load_s = 1'b0;
            mux5_s       = 1'b0;
        end else if (issue_s) begin
            mux5_s = 1'b0;
        end else begin
            mux5_s = 1'b1;
        end
    end

    // saturating count of cycles in which the PC was held
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (!pc_load_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.pc_load       = pc_load_s;
    assign bus.if_id_load    = if_id_load_s;
    assign bus.if_id_flush   = if_id_flush_s;
    assign bus.mux5_selector = mux5_s;
    assign bus.stall_cycles  = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: a cycle-age reference model predicts every output,
// a negedge monitor compares; directed hazard/branch/reset scenarios then randomized traffic.
module tb_pipeline_controller;

    localparam int DEPTH      = 3;
    localparam int BRANCH_LAT = 2;
    localparam int CNT_W      = 4;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipeline_controller_if #(.CNT_W(CNT_W)) bus ();

    pipeline_controller #(.DEPTH(DEPTH), .BRANCH_LAT(BRANCH_LAT), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic             pc_load;
        logic             if_id_load;
        logic             if_id_flush;
        logic             mux5;
        logic [CNT_W-1:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference state: cycle numbers, not pipeline registers
    int cyc = 0;
    int last_wr[32];
    int br_cyc = -1000;
    int stall_cnt = 0;

    function automatic bit f_reads1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011, 7'b1100111};
    endfunction
    function automatic bit f_reads2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction
    function automatic bit f_writes(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b1101111, 7'b1100111,
                          7'b0110111, 7'b0010111};
    endfunction
    function automatic bit f_ctrl(input logic [6:0] op);
        return op inside {7'b1100011, 7'b1101111, 7'b1100111};
    endfunction
    function automatic bit recent(input logic [4:0] r);
        int age;
        age = cyc - last_wr[r];
        return (r != 5'd0) && (age >= 1) && (age <= DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) last_wr[i] = -1000;
        br_cyc    = -1000;
        stall_cnt = 0;
    endtask

    // drive one cycle, predict its outputs, advance the model over the coming edge
    task automatic step(input logic rst, input logic v, input logic [6:0] op,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                        input logic bt, output logic iss);
        exp_t e;
        bit   hz, inbr, res;
        int   age;
        @(posedge clock);
        #1;
        reset = rst; bus.id_valid = v; bus.opcode = op;
        bus.rs1 = r1; bus.rs2 = r2; bus.rd = d; bus.branch_taken = bt;
        age  = cyc - br_cyc;
        inbr = (age >= 1) && (age <= BRANCH_LAT);
        res  = (age == BRANCH_LAT);
        hz   = v && ((f_reads1(op) && recent(r1)) || (f_reads2(op) && recent(r2)));
        iss  = 1'b0;
        if (rst)                  e = '{1'b0, 1'b0, 1'b0, 1'b1, '0};
        else if (inbr && !res)    e = '{1'b0, 1'b0, 1'b0, 1'b1, '0};
        else if (res)             e = '{1'b1, 1'b1, bt,   1'b1, '0};
        else if (hz)              e = '{1'b0, 1'b0, 1'b0, 1'b1, '0};
        else if (v && f_ctrl(op)) begin e = '{1'b0, 1'b0, 1'b0, 1'b0, '0}; iss = 1'b1; end
        else if (v)               begin e = '{1'b1, 1'b1, 1'b0, 1'b0, '0}; iss = 1'b1; end
        else                      e = '{1'b1, 1'b1, 1'b0, 1'b1, '0};
        e.stall = CNT_W'(stall_cnt);
        exp_q.push_back(e);
        if (rst) begin
            model_reset();
        end else begin
            if (iss && f_writes(op) && d != 5'd0) last_wr[d] = cyc;
            if (iss && f_ctrl(op)) br_cyc = cyc;
            if (!e.pc_load && stall_cnt < CNT_SAT) stall_cnt++;
        end
        cyc++;
    endtask

    // hold one instruction in ID until it issues; returns cycles spent
    task automatic present(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] d, output int tries);
        logic iss;
        iss = 1'b0;
        tries = 0;
        while (!iss && tries < 20) begin
            step(1'b0, 1'b1, op, r1, r2, d, 1'b0, iss);
            tries++;
        end
        if (!iss) begin
            checks++; errors++;
            $display("FAIL issue_timeout: op=%b not issued after %0d cycles", op, tries);
        end
    endtask

    task automatic expect_tries(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: issued after %0d cycles, required %0d", name, got, want);
        end
    endtask

    // monitor: compare every presented cycle against the queued prediction
    always @(negedge clock) begin
        exp_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{bus.pc_load, bus.if_id_load, bus.if_id_flush, bus.mux5_selector, bus.stall_cycles};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t {pc,ifid,flush,mux5,stall}: actual %b required %b",
                         $time, a, e);
            end
        end
    end

    initial begin
        logic       iss;
        int         t;
        logic [6:0] ops[12] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011,
                                7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011,
                                7'b0010011, 7'b1111111};
        logic [6:0] op;
        logic [4:0] a, b, d;
        logic       pend, rst;

        bus.id_valid = 1'b0; bus.opcode = 7'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        bus.rd = 5'd0; bus.branch_taken = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, iss);
        step(1'b1, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, iss);

        // RAW on rd=x5: three stall cycles, issue on the fourth
        present(7'b0110011, 5'd1, 5'd2, 5'd5, t);  expect_tries("producer_x5", t, 1);
        present(7'b0110011, 5'd5, 5'd1, 5'd6, t);  expect_tries("raw_rs1_x5", t, DEPTH + 1);

        // x0 never creates a dependency; rs2 only matters for rs2 readers
        step(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, iss);
        step(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, iss);
        step(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, iss);
        present(7'b0110011, 5'd1, 5'd2, 5'd0, t);  expect_tries("write_x0", t, 1);
        present(7'b0110011, 5'd0, 5'd0, 5'd3, t);  expect_tries("read_x0", t, 1);
        present(7'b0000011, 5'd1, 5'd0, 5'd7, t);  expect_tries("load_x7", t, 1);
        present(7'b0000011, 5'd0, 5'd7, 5'd0, t);  expect_tries("load_ignores_rs2", t, 1);
        present(7'b0110011, 5'd0, 5'd7, 5'd8, t);  expect_tries("raw_rs2_x7", t, DEPTH);

        // branch taken, then not taken with a stray pulse in the wait cycle
        present(7'b1100011, 5'd0, 5'd0, 5'd0, t);  expect_tries("beq_taken", t, 1);
        step(1'b0, 1'b1, 7'b0110011, 5'd0, 5'd0, 5'd0, 1'b0, iss);
        step(1'b0, 1'b1, 7'b0110011, 5'd0, 5'd0, 5'd0, 1'b1, iss);
        present(7'b1100011, 5'd0, 5'd0, 5'd0, t);  expect_tries("beq_not_taken", t, 1);
        step(1'b0, 1'b1, 7'b0110011, 5'd0, 5'd0, 5'd0, 1'b1, iss);
        step(1'b0, 1'b1, 7'b0110011, 5'd0, 5'd0, 5'd0, 1'b0, iss);

        // reset in the middle of a branch wait clears FSM, scoreboard and counter
        present(7'b0110011, 5'd0, 5'd0, 5'd9, t);
        present(7'b1101111, 5'd0, 5'd0, 5'd0, t);  expect_tries("jal_issue", t, 1);
        step(1'b1, 1'b1, 7'b0110011, 5'd0, 5'd0, 5'd0, 1'b1, iss);
        step(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, iss);
        present(7'b0110011, 5'd9, 5'd0, 5'd0, t);  expect_tries("sb_cleared", t, 1);

        // dependent chain drives the 4-bit counter into saturation
        present(7'b0010011, 5'd1, 5'd0, 5'd10, t);
        for (int i = 0; i < 7; i++) present(7'b0010011, 5'd10, 5'd0, 5'd10, t);
        step(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, iss);
        @(negedge clock);
        checks++;
        if (bus.stall_cycles !== CNT_W'(CNT_SAT)) begin
            errors++;
            $display("FAIL stall_saturate: actual %0d required %0d", bus.stall_cycles, CNT_SAT);
        end

        // randomized traffic: instructions held until issued, occasional resets
        pend = 1'b0; op = 7'd0; a = 5'd0; b = 5'd0; d = 5'd0;
        for (int i = 0; i < 1500; i++) begin
            if (!pend) begin
                op   = ops[$urandom_range(0, 11)];
                a    = 5'($urandom_range(0, 7));
                b    = 5'($urandom_range(0, 7));
                d    = 5'($urandom_range(0, 7));
                pend = ($urandom_range(0, 9) != 0);
            end
            rst = ($urandom_range(0, 79) == 0);
            step(rst, pend, op, a, b, d, 1'($urandom_range(0, 1)), iss);
            if (iss || rst) pend = 1'b0;
        end

        @(negedge clock);
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
